rx_engine: RTL and testbench
============================

Name: rx_engine

Overview:
Receive-side counterpart of the arbiter transmit path. It accepts packets from the network AXI-Stream ingress, classifies each packet by the type field in its first beat, and steers the whole packet to one of three egress streams: bulk data to the application, handshakes to the application, or handshake acknowledgements. Unknown and oversize packets are dropped or truncated and counted. Each egress has a registered slice, so there are no combinational ready paths to the network.

Parameters:
DATA_W, 512, TDATA width; TKEEP/TSTRB width = DATA_W/8
DEST_W, 16, TDEST width
TYPE_LSB, 0, LSB of the packet-type field in first-beat TDATA
MAX_BEATS, 32, maximum beats per packet including header; 2..256
CNT_W, 16, width of error counters

Ports:
ap_clk  in  1  clock
ap_rst  in  1  asynchronous, active-high reset
network_rx_TDATA/TKEEP/TSTRB/TLAST/TDEST/TVALID  in  DATA_W/DATA_W/8/DATA_W/8/1/DEST_W/1  network ingress
network_rx_TREADY  out  1  ingress ready
net2app_data_rx_{TDATA,TKEEP,TSTRB,TLAST,TDEST,TVALID}  out  as ingress  bulk data to application
net2app_data_rx_TREADY  in  1
net2app_hs_rx_{...}  out  as ingress  handshake requests to application
net2app_hs_rx_TREADY  in  1
hs_ack_rx_{...}  out  as ingress  handshake acks to transmit side
hs_ack_rx_TREADY  in  1
drop_count  out  CNT_W  packets dropped (unknown type), saturating
trunc_count  out  CNT_W  packets truncated (oversize), saturating
busy  out  1  mid-packet (FSM not IDLE)

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, all slices empty, all egress TVALID=0, network_rx_TREADY=0 while ap_rst=1, counters=0, busy=0.
- Type field is first-beat TDATA[TYPE_LSB+3:TYPE_LSB]:
  - 4'h1 -> net2app_hs_rx
  - 4'h2 -> hs_ack_rx
  - 4'h4 -> net2app_data_rx
  - any other value -> DROP
- FSM states:
  - IDLE: on an ingress handshake, decode the type, latch the destination, and emit beat 1. If TLAST=1, stay in IDLE. Otherwise go to FWD, or to DROP for an unknown type.
  - FWD: forward beats to the latched destination. TLAST returns to IDLE.
  - DROP: consume beats with ready=1 and discard them. TLAST returns to IDLE. drop_count increments once per packet, at the first beat.
  - TRUNC: consume and discard beats until TLAST, then return to IDLE.
- Beat counter: 8 bits, 1 at the header beat, incremented per accepted beat. When a beat is accepted in FWD with count==MAX_BEATS and TLAST=0:
  - forward that beat with TLAST forced to 1;
  - increment trunc_count;
  - go to TRUNC.
  - A packet of exactly MAX_BEATS beats is not truncated.
- network_rx_TREADY:
  - IDLE: 1 only if all three slices can accept.
  - FWD: the selected slice's s_ready.
  - DROP/TRUNC: 1.
  - Ready never depends combinationally on any egress TREADY.
- Latency: ingress beat to egress TVALID is 1 cycle. Full throughput of 1 beat/cycle when the sink holds TREADY=1.
- Payload: TDATA/TKEEP/TSTRB/TDEST pass unmodified, including the header beat. The only field altered is TLAST on truncation.
- Backpressure: one stalled egress blocks the ingress. There is no reordering between packets.
- Counters saturate at all-ones and do not wrap.
- Reset mid-packet: the partial packet is lost and slices are flushed. The first post-reset beat is decoded as a header.
- Packet spacing: a TLAST beat and the next packet's header may be on consecutive cycles with no bubble.

Decomposition:
- Package rx_engine_pkg holds:
  - type codes PKT_HS_REQ=4'h1, PKT_HS_ACK=4'h2, PKT_DATA=4'h4;
  - FSM state enum IDLE/FWD/DROP/TRUNC;
  - type field width 4.
- Sub-module axis_reg_slice: a 2-entry skid buffer, instantiated 3×. Its s_ready is registered. It is reused later by tx_engine.

Test Plan:
1. 1-beat type 4'h1 packet (TDATA=0x...A1, TDEST=3), all sinks ready -> net2app_hs_rx valid next cycle, same data, TLAST=1; other egresses idle; busy stays 0.
2. 4-beat type 4'h4 packet, back-to-back with a 1-beat type 4'h2 packet -> 4 beats on net2app_data_rx, then 1 on hs_ack_rx, no bubble; counters remain 0.
3. 3-beat type 4'h7 packet -> network_rx_TREADY=1 throughout, no egress TVALID, drop_count=1.
4. 40-beat data packet, MAX_BEATS=32 -> 32 beats out, beat 32 with TLAST=1, 8 discarded, trunc_count=1. A 32-beat packet -> no truncation.
5. net2app_data_rx_TREADY=0 for 10 cycles mid-packet -> ingress stalls within 2 cycles, no beat lost or duplicated, order preserved on release.
6. ap_rst pulse on beat 2 of a 5-beat data packet -> all TVALID=0 immediately; after release, the next beat is decoded as a header; counters=0.

Source files
------------

// File: rtl/rx_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module     : rx_engine_pkg
// Purpose    : Shared types and constants for the receive engine. This covers
//              packet type codes, the FSM state encoding, egress selection and
//              the header decode helper.
// Revision   : 1.0 - initial release
// ============================================================================
package rx_engine_pkg;

  // Width of the packet-type field carried in the first beat
  localparam int TYPE_W = 4;
  localparam int NUM_EG = 3;

  localparam logic [TYPE_W-1:0] PKT_HS_REQ = 4'h1;
  localparam logic [TYPE_W-1:0] PKT_HS_ACK = 4'h2;
  localparam logic [TYPE_W-1:0] PKT_DATA   = 4'h4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FWD   = 2'd1,
    DROP  = 2'd2,
    TRUNC = 2'd3
  } rx_state_e;

  // Egress index; also used as the index into the slice array
  typedef enum logic [1:0] {
    EG_HS   = 2'd0,
    EG_ACK  = 2'd1,
    EG_DATA = 2'd2
  } egress_e;

  typedef struct packed {
    logic    known;
    egress_e eg;
  } route_t;

  function automatic route_t route_of(input logic [TYPE_W-1:0] t);
    route_t r;
    r.known = 1'b1;
    r.eg    = EG_DATA;
    case (t)
      PKT_HS_REQ: r.eg = EG_HS;
      PKT_HS_ACK: r.eg = EG_ACK;
      PKT_DATA:   r.eg = EG_DATA;
      default:    r.known = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_engine_axis_reg_slice.sv
`default_nettype none
// ============================================================================
// Module     : axis_reg_slice
// Purpose    : Two-entry AXI-Stream skid buffer with a registered s_ready.
//              The output payload comes straight from storage registers, and
//              the upstream ready is a flop. No combinational path runs from
//              m_ready_i to s_ready_o.
// Ports      : clk_i, rst_i (async, active-high)
//              s_data_i/s_valid_i/s_ready_o  - upstream side
//              m_data_o/m_valid_o/m_ready_i  - downstream side
// Revision   : 1.0 - initial release
// ============================================================================
module axis_reg_slice #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] s_data_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  output logic [W-1:0] m_data_o,
  output logic         m_valid_o,
  input  logic         m_ready_i
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         s_ready_q;
  logic         w_push;
  logic         w_pop;

  assign w_push    = s_valid_i & s_ready_q;
  assign w_pop     = (count_q != 2'd0) & m_ready_i;
  assign s_ready_o = s_ready_q;
  assign m_valid_o = (count_q != 2'd0);
  assign m_data_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // s_ready is computed from next occupancy. The second entry absorbs the
  // beat that arrives in the cycle ready is seen deasserting.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q   <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      s_ready_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      s_ready_q <= (count_d != 2'd2);
      if (w_push) wr_ptr_q <= ~wr_ptr_q;
      if (w_pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Payload storage needs no reset; validity is tracked by count_q
  always_ff @(posedge clk_i) begin
    if (w_push) mem_q[wr_ptr_q] <= s_data_i;
  end

endmodule
`default_nettype wire

// File: rtl/rx_engine.sv
`default_nettype none
// ============================================================================
// Module     : rx_engine
// Purpose    : Receive-side packet steering. The type field in the first beat
//              of each ingress packet selects one of three egress streams
//              (handshake request, handshake ack, bulk data). Unknown types
//              are dropped. Packets longer than MAX_BEATS are cut short with
//              a forced TLAST. Each egress passes through a registered skid
//              slice.
// Ports      : ap_clk, ap_rst (async, active-high)
//              network_rx_*       - AXI-Stream ingress
//              net2app_data_rx_*  - bulk data egress
//              net2app_hs_rx_*    - handshake request egress
//              hs_ack_rx_*        - handshake ack egress
//              drop_count, trunc_count - saturating error counters
//              busy               - high while inside a packet
// Revision   : 1.0 - initial release
// ============================================================================
module rx_engine
  import rx_engine_pkg::*;
#(
  parameter int DATA_W    = 512,
  parameter int DEST_W    = 16,
  parameter int TYPE_LSB  = 0,
  parameter int MAX_BEATS = 32,
  parameter int CNT_W     = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,

  input  logic [DATA_W-1:0]     network_rx_TDATA,
  input  logic [DATA_W/8-1:0]   network_rx_TKEEP,
  input  logic [DATA_W/8-1:0]   network_rx_TSTRB,
  input  logic                  network_rx_TLAST,
  input  logic [DEST_W-1:0]     network_rx_TDEST,
  input  logic                  network_rx_TVALID,
  output logic                  network_rx_TREADY,

  output logic [DATA_W-1:0]     net2app_data_rx_TDATA,
  output logic [DATA_W/8-1:0]   net2app_data_rx_TKEEP,
  output logic [DATA_W/8-1:0]   net2app_data_rx_TSTRB,
  output logic                  net2app_data_rx_TLAST,
  output logic [DEST_W-1:0]     net2app_data_rx_TDEST,
  output logic                  net2app_data_rx_TVALID,
  input  logic                  net2app_data_rx_TREADY,

  output logic [DATA_W-1:0]     net2app_hs_rx_TDATA,
  output logic [DATA_W/8-1:0]   net2app_hs_rx_TKEEP,
  output logic [DATA_W/8-1:0]   net2app_hs_rx_TSTRB,
  output logic                  net2app_hs_rx_TLAST,
  output logic [DEST_W-1:0]     net2app_hs_rx_TDEST,
  output logic                  net2app_hs_rx_TVALID,
  input  logic                  net2app_hs_rx_TREADY,

  output logic [DATA_W-1:0]     hs_ack_rx_TDATA,
  output logic [DATA_W/8-1:0]   hs_ack_rx_TKEEP,
  output logic [DATA_W/8-1:0]   hs_ack_rx_TSTRB,
  output logic                  hs_ack_rx_TLAST,
  output logic [DEST_W-1:0]     hs_ack_rx_TDEST,
  output logic                  hs_ack_rx_TVALID,
  input  logic                  hs_ack_rx_TREADY,

  output logic [CNT_W-1:0]      drop_count,
  output logic [CNT_W-1:0]      trunc_count,
  output logic                  busy
);

  localparam int KEEP_W   = DATA_W / 8;
  localparam int LAST_POS = DATA_W + 2 * KEEP_W;
  localparam int BEAT_W   = LAST_POS + 1 + DEST_W;
  // Beat index of the final permitted beat (the header is index 0)
  localparam logic [7:0] LAST_IDX = 8'(MAX_BEATS - 1);

  rx_state_e            state_q;
  egress_e              sel_q;
  logic [7:0]           beat_idx_q;
  logic [CNT_W-1:0]     drop_cnt_q;
  logic [CNT_W-1:0]     trunc_cnt_q;

  route_t               w_route;
  logic                 w_in_ready;
  logic                 w_in_fire;
  logic                 w_trunc_now;
  logic                 w_push_en;
  egress_e              w_target;
  logic [BEAT_W-1:0]    w_in_beat;
  logic [BEAT_W-1:0]    w_fwd_beat;
  logic [NUM_EG-1:0]    w_s_ready;
  logic [NUM_EG-1:0]    w_push;
  logic [NUM_EG-1:0]    w_m_valid;
  logic [NUM_EG-1:0]    w_m_ready;
  logic [BEAT_W-1:0]    w_m_beat [NUM_EG];

  assign w_route   = route_of(network_rx_TDATA[TYPE_LSB +: TYPE_W]);
  assign w_in_beat = {network_rx_TDEST, network_rx_TLAST, network_rx_TSTRB,
                      network_rx_TKEEP, network_rx_TDATA};

  // Ingress ready is derived only from registered state and the registered
  // slice readies. In IDLE the destination is still unknown, so every
  // slice must have room.
  always_comb begin
    w_in_ready = 1'b0;
    case (state_q)
      IDLE:    w_in_ready = &w_s_ready;
      FWD:     w_in_ready = w_s_ready[sel_q];
      default: w_in_ready = 1'b1;
    endcase
  end

  assign network_rx_TREADY = w_in_ready;
  assign w_in_fire   = network_rx_TVALID & w_in_ready;
  assign w_trunc_now = (state_q == FWD) && (beat_idx_q == LAST_IDX) && !network_rx_TLAST;
  assign w_target    = (state_q == IDLE) ? w_route.eg : sel_q;
  assign w_push_en   = w_in_fire &
                       (((state_q == IDLE) && w_route.known) || (state_q == FWD));

  always_comb begin
    w_fwd_beat           = w_in_beat;
    w_fwd_beat[LAST_POS] = network_rx_TLAST | w_trunc_now;
  end

  assign w_m_ready[EG_HS]   = net2app_hs_rx_TREADY;
  assign w_m_ready[EG_ACK]  = hs_ack_rx_TREADY;
  assign w_m_ready[EG_DATA] = net2app_data_rx_TREADY;

  for (genvar k = 0; k < NUM_EG; k++) begin : g_slice
    assign w_push[k] = w_push_en && (w_target == egress_e'(2'(k)));

    axis_reg_slice #(
      .W (BEAT_W)
    ) u_slice (
      .clk_i     (ap_clk),
      .rst_i     (ap_rst),
      .s_data_i  (w_fwd_beat),
      .s_valid_i (w_push[k]),
      .s_ready_o (w_s_ready[k]),
      .m_data_o  (w_m_beat[k]),
      .m_valid_o (w_m_valid[k]),
      .m_ready_i (w_m_ready[k])
    );
  end

  // beat_idx_q holds the zero-based index of the next beat to arrive
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q     <= IDLE;
      sel_q       <= EG_HS;
      beat_idx_q  <= 8'd0;
      drop_cnt_q  <= '0;
      trunc_cnt_q <= '0;
    end else if (w_in_fire) begin
      case (state_q)
        IDLE: begin
          beat_idx_q <= 8'd1;
          if (w_route.known) begin
            sel_q <= w_route.eg;
            if (!network_rx_TLAST) state_q <= FWD;
          end else begin
            if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
            if (!network_rx_TLAST) state_q <= DROP;
          end
        end
        FWD: begin
          if (network_rx_TLAST) begin
            state_q <= IDLE;
          end else if (w_trunc_now) begin
            state_q <= TRUNC;
            if (trunc_cnt_q != '1) trunc_cnt_q <= trunc_cnt_q + 1'b1;
          end else begin
            beat_idx_q <= beat_idx_q + 8'd1;
          end
        end
        DROP, TRUNC: begin
          if (network_rx_TLAST) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign drop_count  = drop_cnt_q;
  assign trunc_count = trunc_cnt_q;
  assign busy        = (state_q != IDLE);

  assign {net2app_hs_rx_TDEST, net2app_hs_rx_TLAST, net2app_hs_rx_TSTRB,
          net2app_hs_rx_TKEEP, net2app_hs_rx_TDATA} = w_m_beat[EG_HS];
  assign net2app_hs_rx_TVALID = w_m_valid[EG_HS];

  assign {hs_ack_rx_TDEST, hs_ack_rx_TLAST, hs_ack_rx_TSTRB,
          hs_ack_rx_TKEEP, hs_ack_rx_TDATA} = w_m_beat[EG_ACK];
  assign hs_ack_rx_TVALID = w_m_valid[EG_ACK];

  assign {net2app_data_rx_TDEST, net2app_data_rx_TLAST, net2app_data_rx_TSTRB,
          net2app_data_rx_TKEEP, net2app_data_rx_TDATA} = w_m_beat[EG_DATA];
  assign net2app_data_rx_TVALID = w_m_valid[EG_DATA];

endmodule
`default_nettype wire

// File: tb/tb_rx_engine.sv
`default_nettype none
// ============================================================================
// Module     : tb_rx_engine
// Purpose    : Scoreboard bench for rx_engine. A packet-level model predicts
//              which egress each packet reaches, how many beats survive, and
//              the counter values. A monitor pops expected beats as the DUT
//              emits them.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_rx_engine;

  localparam int DATA_W    = 64;
  localparam int KEEP_W    = DATA_W / 8;
  localparam int DEST_W    = 16;
  localparam int MAX_BEATS = 32;
  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
  localparam int BW        = DATA_W + 2 * KEEP_W + 1 + DEST_W;

  typedef logic [BW-1:0] beat_t;

  logic clk;
  logic ap_rst;

  logic [DATA_W-1:0] rx_tdata;
  logic [KEEP_W-1:0] rx_tkeep, rx_tstrb;
  logic              rx_tlast, rx_tvalid, rx_tready;
  logic [DEST_W-1:0] rx_tdest;

  logic [DATA_W-1:0] d_tdata, h_tdata, a_tdata;
  logic [KEEP_W-1:0] d_tkeep, h_tkeep, a_tkeep, d_tstrb, h_tstrb, a_tstrb;
  logic              d_tlast, h_tlast, a_tlast, d_tvalid, h_tvalid, a_tvalid;
  logic [DEST_W-1:0] d_tdest, h_tdest, a_tdest;
  logic [2:0]        sink_rdy;
  logic [CNT_W-1:0]  drop_count, trunc_count;
  logic              busy;

  beat_t       eg_beat [3];
  logic [2:0]  eg_valid;
  beat_t       exp_q [3][$];

  int n_pass, n_total;
  int model_drop, model_trunc;
  int in_fires;
  int cyc;
  int sink_mode;

  rx_engine #(
    .DATA_W(DATA_W), .DEST_W(DEST_W), .TYPE_LSB(0),
    .MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)
  ) dut (
    .ap_clk(clk), .ap_rst(ap_rst),
    .network_rx_TDATA(rx_tdata), .network_rx_TKEEP(rx_tkeep),
    .network_rx_TSTRB(rx_tstrb), .network_rx_TLAST(rx_tlast),
    .network_rx_TDEST(rx_tdest), .network_rx_TVALID(rx_tvalid),
    .network_rx_TREADY(rx_tready),
    .net2app_data_rx_TDATA(d_tdata), .net2app_data_rx_TKEEP(d_tkeep),
    .net2app_data_rx_TSTRB(d_tstrb), .net2app_data_rx_TLAST(d_tlast),
    .net2app_data_rx_TDEST(d_tdest), .net2app_data_rx_TVALID(d_tvalid),
    .net2app_data_rx_TREADY(sink_rdy[2]),
    .net2app_hs_rx_TDATA(h_tdata), .net2app_hs_rx_TKEEP(h_tkeep),
    .net2app_hs_rx_TSTRB(h_tstrb), .net2app_hs_rx_TLAST(h_tlast),
    .net2app_hs_rx_TDEST(h_tdest), .net2app_hs_rx_TVALID(h_tvalid),
    .net2app_hs_rx_TREADY(sink_rdy[0]),
    .hs_ack_rx_TDATA(a_tdata), .hs_ack_rx_TKEEP(a_tkeep),
    .hs_ack_rx_TSTRB(a_tstrb), .hs_ack_rx_TLAST(a_tlast),
    .hs_ack_rx_TDEST(a_tdest), .hs_ack_rx_TVALID(a_tvalid),
    .hs_ack_rx_TREADY(sink_rdy[1]),
    .drop_count(drop_count), .trunc_count(trunc_count), .busy(busy)
  );

  assign eg_beat[0] = {h_tdest, h_tlast, h_tstrb, h_tkeep, h_tdata};
  assign eg_beat[1] = {a_tdest, a_tlast, a_tstrb, a_tkeep, a_tdata};
  assign eg_beat[2] = {d_tdest, d_tlast, d_tstrb, d_tkeep, d_tdata};
  assign eg_valid   = {d_tvalid, a_tvalid, h_tvalid};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // Hold the current beat until the DUT accepts it, with a bounded wait
  task automatic wait_accept();
    int t = 0;
    bit done = 0;
    while (!done) begin
      @(negedge clk);
      if (rx_tready) done = 1;
      else begin
        t++;
        if (t > 500) begin
          n_total++;
          $display("FAIL ingress accept timeout: waited %0d cycles, limit 500", t);
          done = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Reference: a known type forwards min(n, MAX_BEATS) beats with TLAST on
  // the final forwarded beat. An unknown type forwards nothing.
  task automatic send_pkt(input int n, input logic [3:0] typ, input logic [DEST_W-1:0] dest);
    logic [DATA_W-1:0] d;
    logic [KEEP_W-1:0] kp, st;
    int eg, m;
    case (typ)
      4'h1:    eg = 0;
      4'h2:    eg = 1;
      4'h4:    eg = 2;
      default: eg = -1;
    endcase
    m = (n > MAX_BEATS) ? MAX_BEATS : n;
    if (eg < 0) model_drop = sat_inc(model_drop);
    else if (n > MAX_BEATS) model_trunc = sat_inc(model_trunc);
    for (int i = 0; i < n; i++) begin
      d = {$urandom, $urandom};
      if (i == 0) d[3:0] = typ;
      kp = KEEP_W'($urandom);
      st = KEEP_W'($urandom);
      if (eg >= 0 && i < m) exp_q[eg].push_back({dest, (i == m - 1), st, kp, d});
      rx_tdata  = d;
      rx_tkeep  = kp;
      rx_tstrb  = st;
      rx_tdest  = dest;
      rx_tlast  = (i == n - 1);
      rx_tvalid = 1'b1;
      wait_accept();
    end
    rx_tvalid = 1'b0;
    rx_tlast  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    check("drain remaining beats", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int a, b, c0, n;
    logic [3:0] t;
    n_pass = 0; n_total = 0; model_drop = 0; model_trunc = 0;
    in_fires = 0; cyc = 0; sink_mode = 0; sink_rdy = 3'b111;
    ap_rst = 1'b1;
    rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tdata = '0;
    rx_tkeep = '0; rx_tstrb = '0; rx_tdest = '0;

    fork
      // Scoreboard monitor
      forever begin
        @(negedge clk);
        if (!ap_rst) begin
          for (int k = 0; k < 3; k++) begin
            if (eg_valid[k] && sink_rdy[k]) begin
              if (exp_q[k].size() == 0) begin
                n_total++;
                $display("FAIL unexpected beat on egress %0d: got %0h want none", k, eg_beat[k]);
              end else begin
                check($sformatf("egress%0d beat", k), eg_beat[k], exp_q[k].pop_front());
              end
            end
          end
        end
      end
      // Sink ready driver
      forever begin
        @(posedge clk);
        #1;
        case (sink_mode)
          1:       sink_rdy = {($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 4) != 0};
          2:       sink_rdy = 3'b011;
          default: sink_rdy = 3'b111;
        endcase
      end
      // Ingress acceptance counter
      forever begin
        @(negedge clk);
        if (rx_tvalid && rx_tready) in_fires++;
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset hs TVALID", h_tvalid, 0);
    check("reset ack TVALID", a_tvalid, 0);
    check("reset data TVALID", d_tvalid, 0);
    check("reset ingress TREADY", rx_tready, 0);
    check("reset busy", busy, 0);
    check("reset drop_count", drop_count, 0);
    check("reset trunc_count", trunc_count, 0);
    ap_rst = 1'b0;
    @(posedge clk);
    #1;

    // 1-beat handshake request, one-cycle latency
    send_pkt(1, 4'h1, 16'd3);
    check("latency hs TVALID", h_tvalid, 1);
    check("latency ack idle", a_tvalid, 0);
    check("latency data idle", d_tvalid, 0);
    check("single-beat busy", busy, 0);
    drain();

    // 4-beat data then 1-beat ack, back to back with no bubble
    c0 = cyc;
    send_pkt(4, 4'h4, 16'h1234);
    send_pkt(1, 4'h2, 16'h0042);
    check("back-to-back ingress cycles", cyc - c0, 5);
    drain();
    check("counters after b2b drop", drop_count, model_drop);
    check("counters after b2b trunc", trunc_count, model_trunc);

    // Unknown type is consumed at full rate and counted
    c0 = cyc;
    send_pkt(3, 4'h7, 16'h0007);
    check("drop ingress cycles", cyc - c0, 3);
    drain();
    check("drop_count after unknown", drop_count, model_drop);

    // Oversize packet is truncated; exactly MAX_BEATS is not
    send_pkt(40, 4'h4, 16'h0040);
    drain();
    check("trunc_count after 40 beats", trunc_count, model_trunc);
    check("busy after truncation", busy, 0);
    send_pkt(32, 4'h4, 16'h0032);
    drain();
    check("trunc_count after 32 beats", trunc_count, model_trunc);

    // Data sink stalls mid-packet; ingress must stop and resume cleanly
    a = 0; b = 0;
    fork
      send_pkt(20, 4'h4, 16'h0505);
      begin
        repeat (5) @(posedge clk);
        sink_mode = 2;
        repeat (4) @(posedge clk);
        a = in_fires;
        repeat (7) @(posedge clk);
        b = in_fires;
        sink_mode = 0;
      end
    join
    check("ingress stalled under backpressure", b - a, 0);
    drain();

    // Randomized traffic with random sink backpressure
    sink_mode = 1;
    for (int p = 0; p < 150; p++) begin
      case ($urandom % 5)
        0:       t = 4'h1;
        1:       t = 4'h2;
        2, 3:    t = 4'h4;
        default: begin
          t = 4'($urandom);
          while (t == 4'h1 || t == 4'h2 || t == 4'h4) t = 4'($urandom);
        end
      endcase
      n = (($urandom % 8) == 0) ? 31 + int'($urandom % 3) : 1 + int'($urandom % 40);
      send_pkt(n, t, DEST_W'($urandom));
      if (($urandom % 4) == 0) begin
        repeat (1 + $urandom % 3) @(posedge clk);
        #1;
      end
    end
    drain();
    sink_mode = 0;
    drain();
    check("random drop_count", drop_count, model_drop);
    check("random trunc_count", trunc_count, model_trunc);

    // Reset while beat 2 of a data packet is on the bus
    rx_tdata = {$urandom, $urandom};
    rx_tdata[3:0] = 4'h4;
    rx_tkeep = '1; rx_tstrb = '1; rx_tdest = 16'h0066;
    rx_tlast = 1'b0; rx_tvalid = 1'b1;
    wait_accept();
    rx_tdata = {$urandom, $urandom};
    #1;
    ap_rst = 1'b1;
    #1;
    check("mid-reset hs TVALID", h_tvalid, 0);
    check("mid-reset ack TVALID", a_tvalid, 0);
    check("mid-reset data TVALID", d_tvalid, 0);
    check("mid-reset TREADY", rx_tready, 0);
    check("mid-reset busy", busy, 0);
    check("mid-reset drop_count", drop_count, 0);
    check("mid-reset trunc_count", trunc_count, 0);
    model_drop = 0;
    model_trunc = 0;
    rx_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ap_rst = 1'b0;
    send_pkt(2, 4'h2, 16'h0077);
    drain();
    check("post-reset drop_count", drop_count, model_drop);
    check("post-reset trunc_count", trunc_count, model_trunc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
